// File: rtl/msg_scroller.sv
// rtl/msg_scroller.sv - nibble-rotating message scroller for the 7-seg display path
//
// Purpose:
//   Captures a MSG_NIBBLES-digit hex message on a load pulse. The message is
//   then rotated one nibble per step, left or right. Scrolling either loops
//   forever or stops after one full turn. The top WIN_NIBBLES digits are shown
//   on dataBus. A prescaler sets the step rate at one step every STEP_DIV
//   clk3hz cycles. pause freezes the prescaler and the rotation.
//
// Ports:
//   clk3hz   in   1               step clock, all state on rising edge
//   clr      in   1               asynchronous active-low reset
//   load     in   1               1-cycle pulse: capture number, start scrolling
//   number   in   4*MSG_NIBBLES   message to capture
//   dir      in   1               0 = rotate left (msb-ward), 1 = rotate right
//   oneshot  in   1               0 = loop forever, 1 = stop after one full turn
//   pause    in   1               1 = freeze prescaler and rotation
//   w        in   1               display enable
//   finish   in   1               upstream result valid
//   dataBus  out  4*WIN_NIBBLES   window digits or idle pattern
//   busy     out  1               scrolling in progress
//   done     out  1               one-shot turn completed
//   pos      out  POS_W           steps taken mod MSG_NIBBLES
module msg_scroller #(
  parameter int         MSG_NIBBLES = 8,
  parameter int         WIN_NIBBLES = 4,
  parameter int         STEP_DIV    = 1,
  parameter logic [3:0] IDLE_NIBBLE = 4'hA,
  localparam int        POS_W       = (MSG_NIBBLES > 1) ? $clog2(MSG_NIBBLES) : 1
) (
  input  logic                     clk3hz,
  input  logic                     clr,
  input  logic                     load,
  input  logic [4*MSG_NIBBLES-1:0] number,
  input  logic                     dir,
  input  logic                     oneshot,
  input  logic                     pause,
  input  logic                     w,
  input  logic                     finish,
  output logic [4*WIN_NIBBLES-1:0] dataBus,
  output logic                     busy,
  output logic                     done,
  output logic [POS_W-1:0]         pos
);

  localparam int MW    = 4 * MSG_NIBBLES;
  localparam int WW    = 4 * WIN_NIBBLES;
  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(MSG_NIBBLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCROLL = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [MW-1:0]   msg_q,   msg_d;
  logic [POS_W-1:0] pos_q,  pos_d;
  logic [DIV_W-1:0] div_q,  div_d;

  // Rotations are taken from the message concatenated with itself. The slice
  // is then valid for every MSG_NIBBLES >= 1. With a single digit, both
  // slices reduce to the identity.
  logic [2*MW-1:0] msg_dbl;
  logic [MW-1:0]   rot_left;
  logic [MW-1:0]   rot_right;

  always_comb begin
    msg_dbl   = {msg_q, msg_q};
    rot_left  = msg_dbl[2*MW-5 -: MW];
    rot_right = msg_dbl[MW+3 -: MW];
  end

  always_ff @(posedge clk3hz or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      msg_q   <= '0;
      pos_q   <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      pos_q   <= pos_d;
      div_q   <= div_d;
    end
  end

  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    pos_d   = pos_q;
    div_d   = div_q;

    if (load) begin
      // A load restarts scrolling from any state, including DONE.
      msg_d   = number;
      pos_d   = '0;
      div_d   = '0;
      state_d = ST_SCROLL;
    end else begin
      unique case (state_q)
        ST_SCROLL: begin
          if (!pause) begin
            if (div_q == DIV_LAST) begin
              div_d = '0;
              msg_d = dir ? rot_right : rot_left;
              if (pos_q == POS_LAST) begin
                pos_d = '0;
                // Wrapping pos means a full turn is complete. The message is
                // therefore back to its loaded value.
                if (oneshot) state_d = ST_DONE;
              end else begin
                pos_d = pos_q + POS_W'(1);
              end
            end else begin
              div_d = div_q + DIV_W'(1);
            end
          end
        end
        ST_DONE: ;
        ST_IDLE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q == ST_SCROLL);
    done = (state_q == ST_DONE);
    pos  = pos_q;
    if (w && finish && (state_q != ST_IDLE)) begin
      dataBus = msg_q[MW-1 -: WW];
    end else begin
      dataBus = {WIN_NIBBLES{IDLE_NIBBLE}};
    end
  end

endmodule

// File: tb/tb_msg_scroller.sv
// tb/tb_msg_scroller.sv - self-checking bench for msg_scroller
module tb_msg_scroller;

  logic        clk3hz;
  logic        clr;
  logic        load;
  logic [31:0] number;
  logic        dir;
  logic        oneshot;
  logic        pause;
  logic        w;
  logic        finish;

  logic [15:0] data_a;
  logic        busy_a, done_a;
  logic [2:0]  pos_a;

  logic [15:0] data_b;
  logic        busy_b, done_b;
  logic [2:0]  pos_b;

  logic [3:0]  data_c;
  logic        busy_c, done_c;
  logic [0:0]  pos_c;

  int n_tests = 0;
  int n_fail  = 0;

  msg_scroller #(.MSG_NIBBLES(8), .WIN_NIBBLES(4), .STEP_DIV(1), .IDLE_NIBBLE(4'hA)) u_a (
    .clk3hz(clk3hz), .clr(clr), .load(load), .number(number), .dir(dir),
    .oneshot(oneshot), .pause(pause), .w(w), .finish(finish),
    .dataBus(data_a), .busy(busy_a), .done(done_a), .pos(pos_a)
  );

  msg_scroller #(.MSG_NIBBLES(8), .WIN_NIBBLES(4), .STEP_DIV(3), .IDLE_NIBBLE(4'hA)) u_b (
    .clk3hz(clk3hz), .clr(clr), .load(load), .number(number), .dir(dir),
    .oneshot(oneshot), .pause(pause), .w(w), .finish(finish),
    .dataBus(data_b), .busy(busy_b), .done(done_b), .pos(pos_b)
  );

  msg_scroller #(.MSG_NIBBLES(1), .WIN_NIBBLES(1), .STEP_DIV(1), .IDLE_NIBBLE(4'hA)) u_c (
    .clk3hz(clk3hz), .clr(clr), .load(load), .number(number[3:0]), .dir(dir),
    .oneshot(oneshot), .pause(pause), .w(w), .finish(finish),
    .dataBus(data_c), .busy(busy_c), .done(done_c), .pos(pos_c)
  );

  initial begin
    clk3hz = 1'b0;
    forever #5 clk3hz = ~clk3hz;
  end

  typedef struct {
    string       name;
    logic        load, dir, oneshot, pause, w, finish;
    logic [31:0] number;
    logic [15:0] exp_data;
    logic        exp_busy, exp_done;
    logic [2:0]  exp_pos;
  } vec_t;

  vec_t vq[$];

  function automatic void add(string name, logic ld, logic dr, logic os, logic w_i,
                              logic fi, logic [31:0] num, logic [15:0] ed,
                              logic eb, logic edn, logic [2:0] ep);
    vec_t v;
    v.name = name; v.load = ld; v.dir = dr; v.oneshot = os; v.pause = 1'b0;
    v.w = w_i; v.finish = fi; v.number = num; v.exp_data = ed;
    v.exp_busy = eb; v.exp_done = edn; v.exp_pos = ep;
    vq.push_back(v);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk3hz);
    #1;
  endtask

  task automatic check_a(string name, logic [15:0] d, logic b, logic dn, logic [2:0] p);
    check({name, ".data"}, 32'(data_a), 32'(d));
    check({name, ".busy"}, 32'(busy_a), 32'(b));
    check({name, ".done"}, 32'(done_a), 32'(dn));
    check({name, ".pos"},  32'(pos_a),  32'(p));
  endtask

  task automatic check_b(string name, logic [15:0] d, logic [2:0] p);
    check({name, ".data"}, 32'(data_b), 32'(d));
    check({name, ".pos"},  32'(pos_b),  32'(p));
    check({name, ".busy"}, 32'(busy_b), 32'd1);
  endtask

  localparam logic [31:0] MSG1 = 32'h12345678;
  localparam logic [31:0] MSG2 = 32'hABCDEF01;

  initial begin
    logic [15:0] left_seq [8];
    logic [15:0] right_seq [8];
    left_seq  = '{16'h2345, 16'h3456, 16'h4567, 16'h5678, 16'h6781, 16'h7812, 16'h8123, 16'h1234};
    right_seq = '{16'h8123, 16'h7812, 16'h6781, 16'h5678, 16'h4567, 16'h3456, 16'h2345, 16'h1234};

    clr = 1'b0; load = 1'b0; number = '0; dir = 1'b0; oneshot = 1'b0;
    pause = 1'b0; w = 1'b1; finish = 1'b1;
    #2;
    check_a("reset", 16'hAAAA, 1'b0, 1'b0, 3'd0);
    clr = 1'b1;

    // Left loop: full turn and back to the start, still busy.
    add("l_load", 1, 0, 0, 1, 1, MSG1, 16'h1234, 1, 0, 3'd0);
    for (int i = 0; i < 8; i++)
      add($sformatf("l_step%0d", i + 1), 0, 0, 0, 1, 1, MSG1, left_seq[i], 1, 0, 3'((i + 1) % 8));
    // Right loop.
    add("r_load", 1, 1, 0, 1, 1, MSG1, 16'h1234, 1, 0, 3'd0);
    for (int i = 0; i < 8; i++)
      add($sformatf("r_step%0d", i + 1), 0, 1, 0, 1, 1, MSG1, right_seq[i], 1, 0, 3'((i + 1) % 8));
    // One-shot left: done after eight steps, then frozen, then cleared by load.
    add("o_load", 1, 0, 1, 1, 1, MSG1, 16'h1234, 1, 0, 3'd0);
    for (int i = 0; i < 7; i++)
      add($sformatf("o_step%0d", i + 1), 0, 0, 1, 1, 1, MSG1, left_seq[i], 1, 0, 3'(i + 1));
    add("o_step8", 0, 0, 1, 1, 1, MSG1, 16'h1234, 0, 1, 3'd0);
    add("o_hold1", 0, 0, 1, 1, 1, MSG1, 16'h1234, 0, 1, 3'd0);
    add("o_hold2", 0, 0, 1, 1, 1, MSG1, 16'h1234, 0, 1, 3'd0);
    // Reload clears done; blanking does not stop the rotation.
    add("e_load",  1, 0, 0, 1, 1, MSG1, 16'h1234, 1, 0, 3'd0);
    add("e_w0",    0, 0, 0, 0, 1, MSG1, 16'hAAAA, 1, 0, 3'd1);
    add("e_fin0",  0, 0, 0, 1, 0, MSG1, 16'hAAAA, 1, 0, 3'd2);
    add("e_back",  0, 0, 0, 1, 1, MSG1, 16'h4567, 1, 0, 3'd3);
    add("e_s4",    0, 0, 0, 1, 1, MSG1, 16'h5678, 1, 0, 3'd4);
    add("e_s5",    0, 0, 0, 1, 1, MSG1, 16'h6781, 1, 0, 3'd5);
    // Reload at pos 5.
    add("m_load",  1, 0, 0, 1, 1, MSG2, 16'hABCD, 1, 0, 3'd0);
    add("m_s1",    0, 0, 0, 1, 1, MSG2, 16'hBCDE, 1, 0, 3'd1);

    foreach (vq[k]) begin
      load = vq[k].load; dir = vq[k].dir; oneshot = vq[k].oneshot;
      pause = vq[k].pause; w = vq[k].w; finish = vq[k].finish; number = vq[k].number;
      tick();
      check_a(vq[k].name, vq[k].exp_data, vq[k].exp_busy, vq[k].exp_done, vq[k].exp_pos);
    end
    load = 1'b0;

    // Asynchronous clear mid-scroll; load is ignored while clr is low.
    clr = 1'b0;
    #1;
    check_a("clr_async", 16'hAAAA, 1'b0, 1'b0, 3'd0);
    load = 1'b1; number = MSG1;
    tick();
    check_a("clr_load_ign", 16'hAAAA, 1'b0, 1'b0, 3'd0);
    load = 1'b0;
    clr = 1'b1;

    // Prescaler of 3 with a pause in the middle of a count.
    load = 1'b1; number = MSG1; dir = 1'b0; oneshot = 1'b0; pause = 1'b0;
    tick(); load = 1'b0;
    check_b("d_load", 16'h1234, 3'd0);
    tick(); check_b("d_c1", 16'h1234, 3'd0);
    tick(); check_b("d_c2", 16'h1234, 3'd0);
    tick(); check_b("d_step1", 16'h2345, 3'd1);
    tick(); check_b("d_c4", 16'h2345, 3'd1);
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); check_b($sformatf("d_pause%0d", i), 16'h2345, 3'd1);
    end
    pause = 1'b0;
    tick(); check_b("d_resume", 16'h2345, 3'd1);
    tick(); check_b("d_step2", 16'h3456, 3'd2);

    // Single-digit message: identity rotation, one-shot ends on first step.
    clr = 1'b0; #1; clr = 1'b1;
    check("c_reset.data", 32'(data_c), 32'hA);
    load = 1'b1; number = MSG1; oneshot = 1'b1;
    tick(); load = 1'b0;
    check("c_load.data", 32'(data_c), 32'h8);
    check("c_load.busy", 32'(busy_c), 32'd1);
    tick();
    check("c_step.data", 32'(data_c), 32'h8);
    check("c_step.done", 32'(done_c), 32'd1);
    check("c_step.busy", 32'(busy_c), 32'd0);
    check("c_step.pos",  32'(pos_c),  32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
